mcu: RTL and testbench
======================

// Module: mcu
// PURPOSE
//  - Control FSM for the music player: turns the debounced, one-cycle
//    play_pause/next button pulses and the song_done pulse from the note
//    player into three signals:
//      play       run/pause level
//      song       current song index
//      reset_play one-cycle restart strobe for the song reader/note player
//  - Sits between the button conditioners and the song_reader/note_player datapath.
// PARAMETERS
//  SONG_W     2   width of song index; index wraps modulo 2**SONG_W
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  reset       in   1       synchronous, active-low reset
//  play_pause  in   1       one-cycle pulse: toggle play/pause
//  next        in   1       one-cycle pulse: advance to next song
//  song_done   in   1       one-cycle pulse: current song finished
//  play        out  1       1 = player running
//  song        out  SONG_W  current song index
//  reset_play  out  1       1-cycle strobe: restart reader at song start
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-low.
//  - States: ST_RESET, ST_PAUSE, ST_PLAY, ST_NEXT. Registered state; outputs
//    decoded from state/song registers only (Moore, no input->output path).
//  - Reset: reset==0 at a rising edge -> state=ST_RESET, song=0.
//    Held in reset: play=0, song=0, reset_play=1.
//  - ST_RESET: play=0, reset_play=1; next state ST_PAUSE unconditionally.
//  - ST_PAUSE: play=0, reset_play=0.
//      next -> ST_NEXT; else play_pause -> ST_PLAY; else stay.
//      song_done ignored.
//  - ST_PLAY: play=1, reset_play=0. Priority next > play_pause > song_done:
//      next -> ST_NEXT
//      play_pause -> ST_PAUSE
//      song_done -> ST_RESET (song index unchanged, ends paused)
//      else stay.
//  - ST_NEXT: play=0, reset_play=1. song <= song+1 on the edge leaving
//    ST_NEXT, wrapping 3->0. Next state ST_PLAY unconditionally (new song
//    auto-starts). Inputs ignored in this state.
//  - Latency: one input pulse at edge N changes state/outputs visible after
//    edge N. ST_RESET/ST_NEXT each last exactly one cycle.
//  - Multi-cycle input pulses re-evaluate each cycle; no edge detection inside.
//  - Only reset clears song to 0; ST_RESET entered via song_done keeps song.
//  - Illegal state encoding -> ST_RESET on next edge.
// STRUCTURE
//  - Shared package mcu_pkg:
//      state enum/localparams ST_RESET=2'd0, ST_PAUSE=2'd1, ST_PLAY=2'd2, ST_NEXT=2'd3
//      SONG_W default
//  - Single flat module: state register, song counter, output decode.
//    No sub-module needed.
// TESTING
//  - Hold reset=0 3 cycles, release -> play=0, song=0, reset_play=1 during
//    reset and 1 cycle after; then ST_PAUSE, reset_play=0.
//  - From pause, play_pause pulse -> play=1 next cycle. Second pulse 5 cycles
//    later -> play=0. Third pulse -> play=1.
//  - While playing, next pulse -> 1 cycle play=0/reset_play=1, then song=1,
//    play=1, reset_play=0.
//  - While playing song=1, song_done pulse -> 1 cycle reset_play=1, then
//    play=0, song stays 1. play_pause -> play=1.
//  - Four next pulses from song=0 -> song 1,2,3,0 (wrap), reset_play strobe
//    on each.
//  - Simultaneous next+play_pause in ST_PLAY -> ST_NEXT taken. reset=0 mid-play
//    -> play=0, song=0 at next edge.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the music player control FSM.
package mcu_pkg;

    // Default width of the song index; the index wraps modulo 2**SONG_W.
    localparam int SONG_W_DEFAULT = 2;

    // Controller states. The encodings are fixed so that a debugger or
    // checker can decode the raw state value.
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_PAUSE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_NEXT  = 2'd3
    } mcu_state_e;

endpackage : mcu_pkg

// File: rtl/mcu.sv
// Music player control FSM.
//
// Turns the play_pause / next button pulses and the song_done pulse from the
// note player into a play level, a song index and a one-cycle reset_play
// strobe that restarts the song reader.
//
// All outputs are registers. They are loaded from the next state, so the
// outputs always match the current state and no input reaches an output
// combinationally.
//
// Handshake: there is no valid/ready flow control. Every input is a level
// that is sampled on each rising edge. A pulse held for several cycles is
// therefore evaluated again in each of those cycles. ST_RESET and ST_NEXT
// ignore all inputs and last exactly one cycle.
module mcu
    import mcu_pkg::*;
#(
    parameter int SONG_W = SONG_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,       // synchronous, active-low
    input  logic              play_pause,
    input  logic              next,
    input  logic              song_done,
    output logic              play,
    output logic [SONG_W-1:0] song,
    output logic              reset_play,
    output mcu_state_e        state_dbg    // current FSM state, for debug and checkers
);

    mcu_state_e        state_q;
    logic [SONG_W-1:0] song_q;
    logic              play_q;
    logic              reset_play_q;

    // State register, song counter and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_RESET;
            song_q       <= '0;
            play_q       <= 1'b0;
            reset_play_q <= 1'b1;
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_q      <= ST_PAUSE;
                    play_q       <= 1'b0;
                    reset_play_q <= 1'b0;
                end
                ST_PAUSE: begin
                    // song_done is ignored here: nothing is playing.
                    if (next) begin
                        state_q      <= ST_NEXT;
                        play_q       <= 1'b0;
                        reset_play_q <= 1'b1;
                    end else if (play_pause) begin
                        state_q      <= ST_PLAY;
                        play_q       <= 1'b1;
                        reset_play_q <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    // Priority is next, then play_pause, then song_done.
                    if (next) begin
                        state_q      <= ST_NEXT;
                        play_q       <= 1'b0;
                        reset_play_q <= 1'b1;
                    end else if (play_pause) begin
                        state_q      <= ST_PAUSE;
                        play_q       <= 1'b0;
                        reset_play_q <= 1'b0;
                    end else if (song_done) begin
                        // Rewind the finished song and stop. The song index is kept.
                        state_q      <= ST_RESET;
                        play_q       <= 1'b0;
                        reset_play_q <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    // Advance to the next song (wrapping) and start it playing.
                    state_q      <= ST_PLAY;
                    song_q       <= song_q + 1'b1;
                    play_q       <= 1'b1;
                    reset_play_q <= 1'b0;
                end
                default: begin
                    state_q      <= ST_RESET;
                    play_q       <= 1'b0;
                    reset_play_q <= 1'b1;
                end
            endcase
        end
    end

    assign play       = play_q;
    assign song       = song_q;
    assign reset_play = reset_play_q;
    assign state_dbg  = state_q;

endmodule : mcu

// File: tb/tb_mcu.sv
// Directed testbench for the music player control FSM.
module tb_mcu;
    import mcu_pkg::*;

    localparam int SONG_W = 2;

    // Clock and reset.
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b0;
    logic              play_pause = 1'b0;
    logic              next = 1'b0;
    logic              song_done = 1'b0;
    logic              play;
    logic [SONG_W-1:0] song;
    logic              reset_play;
    mcu_state_e        state_dbg;

    int checks = 0;
    int failures = 0;

    mcu #(.SONG_W(SONG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .play_pause (play_pause),
        .next       (next),
        .song_done  (song_done),
        .play       (play),
        .song       (song),
        .reset_play (reset_play),
        .state_dbg  (state_dbg)
    );

    // Advance one rising edge. Outputs are then sampled on the falling edge
    // that follows, away from the active edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive the given pulses for one edge, then release them.
    task automatic pulse(input logic pp, input logic nx, input logic sd);
        play_pause = pp;
        next       = nx;
        song_done  = sd;
        step();
        play_pause = 1'b0;
        next       = 1'b0;
        song_done  = 1'b0;
    endtask

    // Compare all three outputs against the expected values.
    task automatic check(input string tag, input logic exp_play,
                         input logic [SONG_W-1:0] exp_song, input logic exp_rp);
        checks++;
        assert ({play, song, reset_play} === {exp_play, exp_song, exp_rp})
        else begin
            failures++;
            $error("FAIL %s: play/song/reset_play observed %b/%0d/%b expected %b/%0d/%b",
                   tag, play, song, reset_play, exp_play, exp_song, exp_rp);
        end
    endtask

    // Compare the debug state against the expected state.
    task automatic check_state(input string tag, input mcu_state_e exp_st);
        checks++;
        assert (state_dbg === exp_st)
        else begin
            failures++;
            $error("FAIL %s: state observed %0d expected %0d", tag, state_dbg, exp_st);
        end
    endtask

    initial begin
        // Hold reset for three cycles.
        reset = 1'b0;
        @(negedge clk);
        step(); step(); step();
        check("in_reset", 1'b0, 2'd0, 1'b1);
        check_state("in_reset_st", ST_RESET);

        // Release reset. The FSM stays in ST_RESET for one more cycle.
        reset = 1'b1;
        check("rel_reset", 1'b0, 2'd0, 1'b1);
        step();
        check("pause_after_reset", 1'b0, 2'd0, 1'b0);
        check_state("pause_st", ST_PAUSE);

        // song_done is ignored while paused.
        pulse(1'b0, 1'b0, 1'b1);
        check("pause_ignores_done", 1'b0, 2'd0, 1'b0);

        // play_pause toggles the play level.
        pulse(1'b1, 1'b0, 1'b0);
        check("pp1_play", 1'b1, 2'd0, 1'b0);
        step(); step(); step(); step();
        check("play_hold", 1'b1, 2'd0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check("pp2_pause", 1'b0, 2'd0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check("pp3_play", 1'b1, 2'd0, 1'b0);

        // next while playing: one strobe cycle, then song 1 playing.
        pulse(1'b0, 1'b1, 1'b0);
        check("next_strobe", 1'b0, 2'd0, 1'b1);
        check_state("next_st", ST_NEXT);
        step();
        check("next_done", 1'b1, 2'd1, 1'b0);

        // song_done while playing: one strobe cycle, then paused, song kept.
        pulse(1'b0, 1'b0, 1'b1);
        check("done_strobe", 1'b0, 2'd1, 1'b1);
        check_state("done_st", ST_RESET);
        step();
        check("done_paused", 1'b0, 2'd1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check("done_resume", 1'b1, 2'd1, 1'b0);

        // Reset again, then start playing from song 0.
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        pulse(1'b1, 1'b0, 1'b0);
        check("replay_s0", 1'b1, 2'd0, 1'b0);

        // Four next pulses walk the song index 1, 2, 3 and wrap to 0.
        pulse(1'b0, 1'b1, 1'b0);
        check("wrap_strobe1", 1'b0, 2'd0, 1'b1);
        step();
        check("wrap_s1", 1'b1, 2'd1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("wrap_strobe2", 1'b0, 2'd1, 1'b1);
        step();
        check("wrap_s2", 1'b1, 2'd2, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("wrap_strobe3", 1'b0, 2'd2, 1'b1);
        step();
        check("wrap_s3", 1'b1, 2'd3, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("wrap_strobe4", 1'b0, 2'd3, 1'b1);
        step();
        check("wrap_s0", 1'b1, 2'd0, 1'b0);

        // next and play_pause together while playing: next wins.
        pulse(1'b1, 1'b1, 1'b0);
        check("prio_next", 1'b0, 2'd0, 1'b1);
        step();
        check("prio_next_after", 1'b1, 2'd1, 1'b0);

        // play_pause and song_done together while playing: pause wins.
        pulse(1'b1, 1'b0, 1'b1);
        check("prio_pp", 1'b0, 2'd1, 1'b0);
        check_state("prio_pp_st", ST_PAUSE);

        // next while paused goes through ST_NEXT and then auto-plays.
        pulse(1'b0, 1'b1, 1'b0);
        check("pause_next", 1'b0, 2'd1, 1'b1);
        step();
        check("pause_next_after", 1'b1, 2'd2, 1'b0);

        // A next input held high is evaluated again in each cycle.
        next = 1'b1;
        step();
        check("held_next_a", 1'b0, 2'd2, 1'b1);
        step();
        check("held_next_b", 1'b1, 2'd3, 1'b0);
        step();
        check("held_next_c", 1'b0, 2'd3, 1'b1);
        next = 1'b0;
        step();
        check("held_next_d", 1'b1, 2'd0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        step();
        check("pre_reset_play", 1'b1, 2'd1, 1'b0);

        // Reset asserted mid-play clears everything at the next edge.
        reset = 1'b0;
        step();
        check("mid_play_reset", 1'b0, 2'd0, 1'b1);
        check_state("mid_play_reset_st", ST_RESET);
        reset = 1'b1;
        step();
        check("post_reset", 1'b0, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mcu
